uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Parameters
REQ-001 SHALL have parameter SIZE, default 8, meaning data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 8, meaning sample_clock cycles per serial bit.

Interface
REQ-003 SHALL have sample_clock  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have data_bus  input  SIZE  byte to transmit, sampled on accept.
REQ-006 SHALL have xmt_valid  input  1  producer offers data_bus this cycle.
REQ-007 SHALL have xmt_ready  output  1  holding register empty; byte accepted when xmt_valid and xmt_ready are both high at a rising edge.
REQ-008 SHALL have serial_out  output  1  serial line, idle high, registered.
REQ-009 SHALL have busy  output  1  high while a frame is on the line.
REQ-010 SHALL have xmt_done  output  1  one-cycle pulse after the last stop-bit cycle of each frame.

Function
REQ-011 SHALL send the frame in this order: start bit 0, SIZE data bits LSB first, one stop bit 1 (SIZE+2 bits).
REQ-012 SHALL hold each bit on serial_out for exactly OVERSAMPLE sample_clock cycles; default frame length is 80 cycles.
REQ-013 SHALL double-buffer: a SIZE-bit holding register with a full flag feeds a (SIZE+2)-bit shift register; xmt_ready SHALL equal the inverse of the full flag.
REQ-014 SHALL drive serial_out directly from shift register bit 0; shifts fill from the MSB with 1.
REQ-015 SHALL implement two states, IDLE and SENDING, with a sample counter and a bit counter sized for OVERSAMPLE-1 and SIZE+1.
REQ-016 IDLE: busy=0, serial_out=1; when the full flag is set, the next edge SHALL load the shifter with {1, hold, 0}, clear the full flag, clear both counters, and enter SENDING.
REQ-017 Latency: a byte accepted at edge N into an empty IDLE block SHALL load at edge N+1, and serial_out SHALL be 0 from edge N+1 onward.
REQ-018 SENDING: the sample counter SHALL increment each cycle; at OVERSAMPLE-1 it SHALL clear, the shifter SHALL shift right by one, and the bit counter SHALL increment.
REQ-019 End of frame: at bit counter = SIZE+1 and sample counter = OVERSAMPLE-1, xmt_done SHALL pulse on the following cycle.
REQ-020 At end of frame, if the full flag is set, the block SHALL reload the shifter on the same edge and stay in SENDING, giving gapless back-to-back frames; otherwise it SHALL return to IDLE.
REQ-021 Accepts SHALL be possible in either state while the holding register is empty, including in the same cycle the holding register is transferred to the shifter (transfer empties it; a new accept refills it).
REQ-022 While xmt_ready=0, xmt_valid SHALL be ignored and data_bus SHALL not be sampled.
REQ-023 busy SHALL be a registered flag equal to (state==SENDING).

Reset
REQ-024 Assertion of reset, at any time including mid-frame, SHALL immediately force: state IDLE, serial_out=1, shifter all ones, counters 0, hold register 0, full flag 0 (xmt_ready=1), busy=0, xmt_done=0.
REQ-025 A frame interrupted by reset SHALL be discarded and not resumed; after deassertion, the line SHALL stay high until a new accept.

Verification
REQ-026 Single byte: accept 8'hA5 from IDLE -> serial_out 0,1,0,1,0,0,1,0,1,1, each for 8 cycles; xmt_done pulses once, 80 cycles after the start bit begins.
REQ-027 Back-to-back: accept 8'h3C, then 8'hC3 while the first is sending -> two 80-cycle frames with no idle cycle between them; xmt_ready low from the second accept until the second reload.
REQ-028 Backpressure: hold xmt_valid high with changing data while xmt_ready=0 -> only the byte present at each accepting edge is sent; no byte is duplicated or dropped.
REQ-029 Mid-frame reset: assert reset during data bit 3 of 8'hFF -> serial_out=1 without waiting for a clock edge; no xmt_done; the next accepted 8'h00 frame is correct.
REQ-030 Idle line: 200 cycles without xmt_valid after reset -> serial_out constant 1, busy=0, xmt_ready=1.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmitter: a holding register double-buffers bytes into a start/data/stop
// shift register; each serial bit is held for OVERSAMPLE sample_clock cycles.
module uart_transmitter #(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic            sample_clock,
  input  logic            reset,
  input  logic [SIZE-1:0] data_bus,
  input  logic            xmt_valid,
  output logic            xmt_ready,
  output logic            serial_out,
  output logic            busy,
  output logic            xmt_done
);

  localparam int unsigned FRAME_W  = SIZE + 2;
  localparam int unsigned SAMPLE_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W    = $clog2(SIZE + 2);
  localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST    = BIT_W'(SIZE + 1);

  typedef enum logic {IDLE, SENDING} state_t;

  state_t              state, state_n;
  logic [FRAME_W-1:0]  shifter, shifter_n;
  logic [SAMPLE_W-1:0] sample_cnt, sample_n;
  logic [BIT_W-1:0]    bit_cnt, bit_n;
  logic [SIZE-1:0]     hold, hold_n;
  logic                full, full_n;
  logic                busy_n, done_n;
  logic                accept, transfer;

  assign xmt_ready  = ~full;
  assign serial_out = shifter[0];
  assign accept     = xmt_valid & ~full;

  // Holding register: a transfer empties it, an accept in the same cycle refills it.
  always_comb begin
    hold_n = accept ? data_bus : hold;
    full_n = accept | (full & ~transfer);
  end

  // Next-state: frame sequencing and shifter/counter updates.
  always_comb begin
    state_n   = state;
    shifter_n = shifter;
    sample_n  = sample_cnt;
    bit_n     = bit_cnt;
    busy_n    = busy;
    done_n    = 1'b0;
    transfer  = 1'b0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (full) begin
          transfer  = 1'b1;
          shifter_n = {1'b1, hold, 1'b0};
          sample_n  = '0;
          bit_n     = '0;
          state_n   = SENDING;
          busy_n    = 1'b1;
        end
      end
      SENDING: begin
        sample_n = sample_cnt + SAMPLE_W'(1);
        if (sample_cnt == SAMPLE_LAST) begin
          sample_n  = '0;
          shifter_n = {1'b1, shifter[FRAME_W-1:1]};
          bit_n     = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_LAST) begin
            done_n = 1'b1;
            bit_n  = '0;
            // Reload on the final edge so back-to-back frames have no idle gap.
            if (full) begin
              transfer  = 1'b1;
              shifter_n = {1'b1, hold, 1'b0};
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sample_clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shifter    <= '1;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      hold       <= '0;
      full       <= 1'b0;
      busy       <= 1'b0;
      xmt_done   <= 1'b0;
    end else begin
      state      <= state_n;
      shifter    <= shifter_n;
      sample_cnt <= sample_n;
      bit_cnt    <= bit_n;
      hold       <= hold_n;
      full       <= full_n;
      busy       <= busy_n;
      xmt_done   <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: directed frame table, back-to-back,
// backpressure, mid-frame reset and random traffic against a frame-timeline model.
module tb_uart_transmitter;

  localparam int SIZE = 8;
  localparam int OS   = 8;
  localparam int F    = (SIZE + 2) * OS;

  logic            sample_clock = 1'b0;
  logic            reset;
  logic [SIZE-1:0] data_bus;
  logic            xmt_valid;
  logic            xmt_ready;
  logic            serial_out;
  logic            busy;
  logic            xmt_done;

  uart_transmitter #(.SIZE(SIZE), .OVERSAMPLE(OS)) dut (
    .sample_clock(sample_clock),
    .reset       (reset),
    .data_bus    (data_bus),
    .xmt_valid   (xmt_valid),
    .xmt_ready   (xmt_ready),
    .serial_out  (serial_out),
    .busy        (busy),
    .xmt_done    (xmt_done)
  );

  always #5 sample_clock = ~sample_clock;

  // Reference model: each accepted byte owns a frame starting at a known edge.
  typedef struct {
    int              start;
    logic [SIZE-1:0] data;
  } frame_t;

  frame_t frames[$];
  int     cyc;
  int     s_last;
  int     a_last;
  bit     have_frame;
  int     checks;
  int     failures;

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
    int         done_lat;
  } vec_t;

  function automatic logic exp_line(int t);
    foreach (frames[i]) begin
      if (t >= frames[i].start && t < frames[i].start + F) begin
        int b;
        b = (t - frames[i].start) / OS;
        if (b == 0) return 1'b0;
        if (b == SIZE + 1) return 1'b1;
        return frames[i].data[b-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(int t);
    foreach (frames[i])
      if (t >= frames[i].start && t < frames[i].start + F) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_done(int t);
    foreach (frames[i])
      if (t == frames[i].start + F) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_ready(int t);
    return !(have_frame && a_last <= t && t < s_last);
  endfunction

  task automatic check(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    frames.delete();
    have_frame = 1'b0;
  endtask

  // One clock edge: update the model with any accept, then compare 1 time unit later.
  task automatic step();
    @(posedge sample_clock);
    cyc++;
    if (!reset && xmt_valid && (!have_frame || cyc > s_last)) begin
      frame_t fr;
      fr.data  = data_bus;
      fr.start = cyc + 1;
      if (have_frame && s_last + F > fr.start) fr.start = s_last + F;
      frames.push_back(fr);
      a_last     = cyc;
      s_last     = fr.start;
      have_frame = 1'b1;
    end
    #1;
    check("serial_out", serial_out, exp_line(cyc));
    check("busy", busy, exp_busy(cyc));
    check("xmt_done", xmt_done, exp_done(cyc));
    check("xmt_ready", xmt_ready, exp_ready(cyc));
  endtask

  task automatic idle(input int n);
    xmt_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [SIZE-1:0] d, output int acc);
    data_bus  = d;
    xmt_valid = 1'b1;
    step();
    acc       = cyc;
    xmt_valid = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    int   acc;
    int   rel;
    int   done_q[$];

    vecs[0] = '{8'hA5, 10'b1101001010, 81};
    vecs[1] = '{8'h00, 10'b1000000000, 81};
    vecs[2] = '{8'hFF, 10'b1111111110, 81};
    vecs[3] = '{8'h3C, 10'b1001111000, 81};
    vecs[4] = '{8'hC3, 10'b1110000110, 81};
    vecs[5] = '{8'h01, 10'b1000000010, 81};

    checks = 0; failures = 0; cyc = 0;
    s_last = 0; a_last = 0; have_frame = 1'b0;
    reset = 1'b0; xmt_valid = 1'b0; data_bus = '0;

    // Reset state before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_serial_out", serial_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", xmt_ready, 1'b1);
    check("rst_done", xmt_done, 1'b0);
    step(); step();
    #2 reset = 1'b0;

    // Idle line after reset.
    idle(200);

    // Directed frame table: mid-bit samples and done latency from the accept edge.
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].data, acc);
      for (int k = 0; k < F + 4; k++) begin
        step();
        rel = cyc - (acc + 1);
        if (rel >= 0 && rel < F && (rel % OS) == OS / 2)
          check("tbl_bit", serial_out, vecs[v].bits[rel / OS]);
        if (cyc == acc + vecs[v].done_lat)
          check("tbl_done", xmt_done, 1'b1);
      end
    end

    // Back-to-back: second byte accepted while the first is on the line.
    send(8'h3C, acc);
    idle(20);
    send(8'hC3, acc);
    check("b2b_ready_low", xmt_ready, 1'b0);
    done_q.delete();
    for (int k = 0; k < 2 * F + 10; k++) begin
      step();
      if (xmt_done) done_q.push_back(cyc);
    end
    check("b2b_two_done", done_q.size() == 2, 1'b1);
    if (done_q.size() == 2) check("b2b_gapless", (done_q[1] - done_q[0]) == F, 1'b1);

    // Backpressure: valid held high with data changing every cycle.
    xmt_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      data_bus = SIZE'($urandom);
      step();
    end
    idle(2 * F + 10);

    // Mid-frame reset during data bit 3 of 8'hFF.
    send(8'hFF, acc);
    while (cyc < acc + 1 + 4 * OS + 3) step();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_serial", serial_out, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", xmt_ready, 1'b1);
    step(); step();
    #2 reset = 1'b0;
    idle(30);
    send(8'h00, acc);
    idle(F + 20);

    // Reset while the start bit is low: the line must rise without a clock edge.
    send(8'h5A, acc);
    while (cyc < acc + 3) step();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("start_rst_serial", serial_out, 1'b1);
    check("start_rst_busy", busy, 1'b0);
    step();
    #2 reset = 1'b0;
    idle(40);

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      xmt_valid = ($urandom_range(0, 3) == 0);
      data_bus  = SIZE'($urandom);
      step();
    end
    idle(2 * F + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
